// File: rtl/alu_iter.sv
// Multi-cycle integer ALU with an iterative shifter that moves SHIFT_STEP bits per cycle.
// Requests and results use valid/ready handshakes; flush discards any in-flight operation.
//
// state | meaning
// IDLE  | ready for a request; single-cycle ops and zero-amount shifts resolve here
// SHIFT | working register shifted by up to SHIFT_STEP bits per cycle
// DONE  | result held on res_data until the consumer takes it
module alu_iter #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [3:0]      req_op,
   input  logic [XLEN-1:0] req_rs1,
   input  logic [XLEN-1:0] req_rs2,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [XLEN-1:0] res_data
);

   localparam int SW = $clog2(XLEN);
   localparam int KW = $clog2(SHIFT_STEP) + 1;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SLL  = 4'd2;
   localparam logic [3:0] OP_SRL  = 4'd3;
   localparam logic [3:0] OP_SRA  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd6;
   localparam logic [3:0] OP_AND  = 4'd7;
   localparam logic [3:0] OP_OR   = 4'd8;
   localparam logic [3:0] OP_XOR  = 4'd9;
   localparam logic [3:0] OP_ROL  = 4'd10;
   localparam logic [3:0] OP_ROR  = 4'd11;
   localparam logic [3:0] OP_MIN  = 4'd12;
   localparam logic [3:0] OP_MAX  = 4'd13;
   localparam logic [3:0] OP_MINU = 4'd14;
   localparam logic [3:0] OP_MAXU = 4'd15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [XLEN-1:0]   work_q;
   logic [3:0]        op_q;
   logic [SW-1:0]     rem_q;

   logic [SW-1:0]     shamt;
   logic              shift_op;
   logic              lt_s;
   logic              lt_u;
   logic [XLEN-1:0]   alu_res;

   logic [SW:0]       rem_ext;
   logic [KW-1:0]     k;
   logic [SW-1:0]     rem_next;
   logic [2*XLEN-1:0] wide;
   logic [2*XLEN-1:0] wide_l;
   logic [2*XLEN-1:0] wide_r;
   logic [XLEN-1:0]   shifted;

   assign req_ready = (state_q == IDLE) && !reset;

   assign shamt    = req_rs2[SW-1:0];
   assign shift_op = (req_op == OP_SLL) || (req_op == OP_SRL) || (req_op == OP_SRA) ||
                     (req_op == OP_ROL) || (req_op == OP_ROR);
   assign lt_s     = $signed(req_rs1) < $signed(req_rs2);
   assign lt_u     = req_rs1 < req_rs2;

   // Shift opcodes fall through to rs1, which is the answer for a zero shift amount.
   always_comb begin
      alu_res = req_rs1;
      case (req_op)
         OP_ADD:  alu_res = req_rs1 + req_rs2;
         OP_SUB:  alu_res = req_rs1 - req_rs2;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
         OP_AND:  alu_res = req_rs1 & req_rs2;
         OP_OR:   alu_res = req_rs1 | req_rs2;
         OP_XOR:  alu_res = req_rs1 ^ req_rs2;
         OP_MIN:  alu_res = lt_s ? req_rs1 : req_rs2;
         OP_MAX:  alu_res = lt_s ? req_rs2 : req_rs1;
         OP_MINU: alu_res = lt_u ? req_rs1 : req_rs2;
         OP_MAXU: alu_res = lt_u ? req_rs2 : req_rs1;
         default: alu_res = req_rs1;
      endcase
   end

   // Step size is bounded by SHIFT_STEP, so the shifter only spans KW amount bits.
   assign rem_ext  = {1'b0, rem_q};
   assign k        = (rem_ext >= (SW+1)'(SHIFT_STEP)) ? KW'(SHIFT_STEP) : rem_ext[KW-1:0];
   assign rem_next = rem_q - SW'(k);
   assign wide     = {work_q, work_q};
   assign wide_l   = wide << k;
   assign wide_r   = wide >> k;

   always_comb begin
      shifted = work_q;
      case (op_q)
         OP_SLL:  shifted = work_q << k;
         OP_SRL:  shifted = work_q >> k;
         OP_SRA:  shifted = $signed(work_q) >>> k;
         OP_ROL:  shifted = wide_l[2*XLEN-1:XLEN];
         OP_ROR:  shifted = wide_r[XLEN-1:0];
         default: shifted = work_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = (shift_op && (shamt != '0)) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            if (rem_next == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         work_q    <= '0;
         op_q      <= '0;
         rem_q     <= '0;
      end else begin
         res_valid <= (state_d == DONE);
         if (!flush) begin
            case (state_q)
               IDLE: begin
                  if (req_valid) begin
                     op_q   <= req_op;
                     work_q <= req_rs1;
                     rem_q  <= shamt;
                     if (state_d == DONE) begin
                        res_data <= alu_res;
                     end
                  end
               end
               SHIFT: begin
                  work_q <= shifted;
                  rem_q  <= rem_next;
                  if (rem_next == '0) begin
                     res_data <= shifted;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_iter.sv
// Directed and randomized checks of alu_iter across several XLEN / SHIFT_STEP configurations.
// Instances 0..3 are XLEN 32 (step 1, 4, 8, 32); instances 4..6 are XLEN 64 (step 1, 8, 64).
module tb_alu_iter;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SLL  = 4'd2;
   localparam logic [3:0] OP_SRL  = 4'd3;
   localparam logic [3:0] OP_SRA  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd6;
   localparam logic [3:0] OP_AND  = 4'd7;
   localparam logic [3:0] OP_OR   = 4'd8;
   localparam logic [3:0] OP_XOR  = 4'd9;
   localparam logic [3:0] OP_ROL  = 4'd10;
   localparam logic [3:0] OP_ROR  = 4'd11;
   localparam logic [3:0] OP_MIN  = 4'd12;
   localparam logic [3:0] OP_MAX  = 4'd13;
   localparam logic [3:0] OP_MINU = 4'd14;
   localparam logic [3:0] OP_MAXU = 4'd15;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic [6:0]  req_valid = '0;
   logic [6:0]  res_ready = '0;
   wire  [6:0]  req_ready;
   wire  [6:0]  res_valid;
   logic [3:0]  req_op  = '0;
   logic [63:0] req_rs1 = '0;
   logic [63:0] req_rs2 = '0;
   wire  [31:0] rd32 [4];
   wire  [63:0] rd64 [3];

   int n_checks = 0;
   int n_fail   = 0;
   int steps [7] = '{1, 4, 8, 32, 1, 8, 64};

   always #5 clock = ~clock;

   alu_iter #(.XLEN(32), .SHIFT_STEP(1)) u0 (
      .clock(clock), .reset(reset), .flush(flush), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_op(req_op), .req_rs1(req_rs1[31:0]), .req_rs2(req_rs2[31:0]), .res_valid(res_valid[0]),
      .res_ready(res_ready[0]), .res_data(rd32[0]));
   alu_iter #(.XLEN(32), .SHIFT_STEP(4)) u1 (
      .clock(clock), .reset(reset), .flush(flush), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_op(req_op), .req_rs1(req_rs1[31:0]), .req_rs2(req_rs2[31:0]), .res_valid(res_valid[1]),
      .res_ready(res_ready[1]), .res_data(rd32[1]));
   alu_iter #(.XLEN(32), .SHIFT_STEP(8)) u2 (
      .clock(clock), .reset(reset), .flush(flush), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_op(req_op), .req_rs1(req_rs1[31:0]), .req_rs2(req_rs2[31:0]), .res_valid(res_valid[2]),
      .res_ready(res_ready[2]), .res_data(rd32[2]));
   alu_iter #(.XLEN(32), .SHIFT_STEP(32)) u3 (
      .clock(clock), .reset(reset), .flush(flush), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
      .req_op(req_op), .req_rs1(req_rs1[31:0]), .req_rs2(req_rs2[31:0]), .res_valid(res_valid[3]),
      .res_ready(res_ready[3]), .res_data(rd32[3]));
   alu_iter #(.XLEN(64), .SHIFT_STEP(1)) u4 (
      .clock(clock), .reset(reset), .flush(flush), .req_valid(req_valid[4]), .req_ready(req_ready[4]),
      .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .res_valid(res_valid[4]),
      .res_ready(res_ready[4]), .res_data(rd64[0]));
   alu_iter #(.XLEN(64), .SHIFT_STEP(8)) u5 (
      .clock(clock), .reset(reset), .flush(flush), .req_valid(req_valid[5]), .req_ready(req_ready[5]),
      .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .res_valid(res_valid[5]),
      .res_ready(res_ready[5]), .res_data(rd64[1]));
   alu_iter #(.XLEN(64), .SHIFT_STEP(64)) u6 (
      .clock(clock), .reset(reset), .flush(flush), .req_valid(req_valid[6]), .req_ready(req_ready[6]),
      .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .res_valid(res_valid[6]),
      .res_ready(res_ready[6]), .res_data(rd64[2]));

   function automatic logic [63:0] get_data(input int idx);
      if (idx < 4) return {32'h0, rd32[idx]};
      return rd64[idx-4];
   endfunction

   function automatic int xlen_of(input int idx);
      return (idx < 4) ? 32 : 64;
   endfunction

   function automatic bit is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROL) || (op == OP_ROR);
   endfunction

   // Bit-at-a-time reference; results are masked to xlen and zero-extended to 64 bits.
   function automatic logic [63:0] ref_alu(input int xlen, input logic [3:0] op,
                                           input logic [63:0] a_in, input logic [63:0] b_in);
      logic [63:0] mask, a, b, r, msb;
      logic signed [63:0] sa, sb;
      int sh;
      mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      a = a_in & mask;
      b = b_in & mask;
      sa = (xlen == 64) ? a : {{32{a[31]}}, a[31:0]};
      sb = (xlen == 64) ? b : {{32{b[31]}}, b[31:0]};
      sh = int'(b & 64'(xlen - 1));
      msb = 64'h1 << (xlen - 1);
      r = a;
      case (op)
         OP_ADD:  r = (a + b) & mask;
         OP_SUB:  r = (a - b) & mask;
         OP_SLL:  for (int i = 0; i < sh; i++) r = (r << 1) & mask;
         OP_SRL:  for (int i = 0; i < sh; i++) r = r >> 1;
         OP_SRA:  for (int i = 0; i < sh; i++) r = (r >> 1) | (r & msb);
         OP_ROL:  for (int i = 0; i < sh; i++) r = ((r << 1) | (r >> (xlen - 1))) & mask;
         OP_ROR:  for (int i = 0; i < sh; i++) r = (r >> 1) | ((r & 64'h1) << (xlen - 1));
         OP_SLT:  r = (sa < sb) ? 64'h1 : 64'h0;
         OP_SLTU: r = (a < b) ? 64'h1 : 64'h0;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_MIN:  r = (sa < sb) ? a : b;
         OP_MAX:  r = (sa < sb) ? b : a;
         OP_MINU: r = (a < b) ? a : b;
         OP_MAXU: r = (a < b) ? b : a;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Issues one op on instance idx and consumes the result; lat = -1 when a bound expires.
   task automatic do_op(input int idx, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] data, output int lat);
      lat  = -1;
      data = 'x;
      @(negedge clock);
      req_op = op;
      req_rs1 = a;
      req_rs2 = b;
      req_valid[idx] = 1'b1;
      res_ready[idx] = 1'b0;
      for (int w = 0; w < 10 && !req_ready[idx]; w++) @(negedge clock);
      if (!req_ready[idx]) begin
         req_valid[idx] = 1'b0;
         return;
      end
      @(negedge clock);
      req_valid[idx] = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         if (res_valid[idx]) begin
            lat = c;
            data = get_data(idx);
            break;
         end
         @(negedge clock);
      end
      if (lat > 0) begin
         res_ready[idx] = 1'b1;
         @(negedge clock);
         res_ready[idx] = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      n_checks++;
      if (req_ready !== 7'b0) begin
         n_fail++; $display("FAIL reset_ready_low: got %b expected %b", req_ready, 7'b0);
      end
      reset = 1'b0;
      @(negedge clock);
      n_checks++;
      if (req_ready !== 7'h7F) begin
         n_fail++; $display("FAIL reset_ready: got %b expected %b", req_ready, 7'h7F);
      end
      n_checks++;
      if (res_valid !== 7'b0) begin
         n_fail++; $display("FAIL reset_valid: got %b expected %b", res_valid, 7'b0);
      end
      for (int i = 0; i < 7; i++) begin
         n_checks++;
         if (get_data(i) !== 64'h0) begin
            n_fail++; $display("FAIL reset_data[%0d]: got %h expected 0", i, get_data(i));
         end
      end
   endtask

   task automatic test_add_sub();
      logic [63:0] d;
      int l;
      do_op(0, OP_ADD, 64'hFFFF_FFFF, 64'h1, d, l);
      n_checks++;
      if (d !== 64'h0) begin n_fail++; $display("FAIL add_wrap: got %h expected %h", d, 64'h0); end
      n_checks++;
      if (l !== 1) begin n_fail++; $display("FAIL add_latency: got %0d expected 1", l); end
      do_op(0, OP_SUB, 64'hFFFF_FFFF, 64'h1, d, l);
      n_checks++;
      if (d !== 64'hFFFF_FFFE) begin n_fail++; $display("FAIL sub: got %h expected %h", d, 64'hFFFF_FFFE); end
      n_checks++;
      if (l !== 1) begin n_fail++; $display("FAIL sub_latency: got %0d expected 1", l); end
      do_op(4, OP_SUB, 64'h0, 64'h1, d, l);
      n_checks++;
      if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL sub64: got %h expected all ones", d); end
   endtask

   task automatic test_shift_step4();
      logic [63:0] d;
      int l;
      do_op(1, OP_SRA, 64'h8000_0000, 64'h5, d, l);
      n_checks++;
      if (d !== 64'hFC00_0000) begin n_fail++; $display("FAIL sra_step4: got %h expected %h", d, 64'hFC00_0000); end
      n_checks++;
      if (l !== 3) begin n_fail++; $display("FAIL sra_step4_latency: got %0d expected 3", l); end
      do_op(1, OP_ROR, 64'h1, 64'h21, d, l);
      n_checks++;
      if (d !== 64'h8000_0000) begin n_fail++; $display("FAIL ror_masked_shamt: got %h expected %h", d, 64'h8000_0000); end
      n_checks++;
      if (l !== 2) begin n_fail++; $display("FAIL ror_latency: got %0d expected 2", l); end
      do_op(1, OP_SLL, 64'h1, 64'h4, d, l);
      n_checks++;
      if (d !== 64'h10 || l !== 2) begin
         n_fail++; $display("FAIL sll_exact_step: got %h/%0d expected 10/2", d, l);
      end
      do_op(3, OP_SRL, 64'h8000_0000, 64'h1F, d, l);
      n_checks++;
      if (d !== 64'h1 || l !== 2) begin
         n_fail++; $display("FAIL srl_full_step: got %h/%0d expected 1/2", d, l);
      end
      do_op(5, OP_ROL, 64'h8000_0000_0000_0001, 64'h3F, d, l);
      n_checks++;
      if (d !== 64'hC000_0000_0000_0000 || l !== 9) begin
         n_fail++; $display("FAIL rol64_step8: got %h/%0d expected c000000000000000/9", d, l);
      end
   endtask

   task automatic test_compare();
      logic [63:0] d;
      int l;
      do_op(0, OP_MIN, 64'hFFFF_FFFF, 64'h1, d, l);
      n_checks++;
      if (d !== 64'hFFFF_FFFF) begin n_fail++; $display("FAIL min_signed: got %h expected %h", d, 64'hFFFF_FFFF); end
      do_op(0, OP_MINU, 64'hFFFF_FFFF, 64'h1, d, l);
      n_checks++;
      if (d !== 64'h1) begin n_fail++; $display("FAIL minu: got %h expected 1", d); end
      do_op(0, OP_SLTU, 64'hFFFF_FFFF, 64'h1, d, l);
      n_checks++;
      if (d !== 64'h0) begin n_fail++; $display("FAIL sltu: got %h expected 0", d); end
      do_op(0, OP_SLT, 64'hFFFF_FFFF, 64'h1, d, l);
      n_checks++;
      if (d !== 64'h1) begin n_fail++; $display("FAIL slt: got %h expected 1", d); end
      do_op(0, OP_MAX, 64'hFFFF_FFFF, 64'h1, d, l);
      n_checks++;
      if (d !== 64'h1) begin n_fail++; $display("FAIL max_signed: got %h expected 1", d); end
   endtask

   task automatic test_shamt_zero();
      logic [63:0] d;
      int l;
      do_op(0, OP_SLL, 64'h1234_5678, 64'h20, d, l);
      n_checks++;
      if (d !== 64'h1234_5678 || l !== 1) begin
         n_fail++; $display("FAIL shamt_zero32: got %h/%0d expected 12345678/1", d, l);
      end
      do_op(5, OP_ROR, 64'hDEAD_BEEF_0000_0001, 64'h40, d, l);
      n_checks++;
      if (d !== 64'hDEAD_BEEF_0000_0001 || l !== 1) begin
         n_fail++; $display("FAIL shamt_zero64: got %h/%0d expected deadbeef00000001/1", d, l);
      end
   endtask

   task automatic test_backpressure();
      @(negedge clock);
      req_op = OP_ADD;
      req_rs1 = 64'h3;
      req_rs2 = 64'h4;
      req_valid[2] = 1'b1;
      res_ready[2] = 1'b0;
      @(negedge clock);
      req_valid[2] = 1'b0;
      for (int c = 0; c < 6; c++) begin
         n_checks++;
         if (res_valid[2] !== 1'b1 || rd32[2] !== 32'h7 || req_ready[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_hold[%0d]: got valid=%b data=%h ready=%b expected 1/7/0",
                     c, res_valid[2], rd32[2], req_ready[2]);
         end
         @(negedge clock);
      end
      res_ready[2] = 1'b1;
      @(negedge clock);
      res_ready[2] = 1'b0;
      n_checks++;
      if (req_ready[2] !== 1'b1 || res_valid[2] !== 1'b0) begin
         n_fail++; $display("FAIL backpressure_release: got ready=%b valid=%b expected 1/0", req_ready[2], res_valid[2]);
      end
   endtask

   task automatic test_flush();
      logic [63:0] d;
      int l;
      bit seen;
      @(negedge clock);
      req_op = OP_SLL;
      req_rs1 = 64'h1;
      req_rs2 = 64'h1F;
      req_valid[0] = 1'b1;
      @(negedge clock);
      req_valid[0] = 1'b0;
      seen = 1'b0;
      for (int c = 1; c < 10; c++) begin
         if (res_valid[0]) seen = 1'b1;
         @(negedge clock);
      end
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      n_checks++;
      if (req_ready[0] !== 1'b1 || res_valid[0] !== 1'b0) begin
         n_fail++; $display("FAIL flush_idle: got ready=%b valid=%b expected 1/0", req_ready[0], res_valid[0]);
      end
      for (int c = 0; c < 40; c++) begin
         if (res_valid[0]) seen = 1'b1;
         @(negedge clock);
      end
      n_checks++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_result: got result=%b expected 0", seen); end
      req_op = OP_XOR;
      req_rs1 = 64'hF0F0_F0F0;
      req_rs2 = 64'hFF00_FF00;
      req_valid[0] = 1'b1;
      flush = 1'b1;
      @(negedge clock);
      req_valid[0] = 1'b0;
      flush = 1'b0;
      n_checks++;
      if (req_ready[0] !== 1'b1 || res_valid[0] !== 1'b0) begin
         n_fail++; $display("FAIL flush_blocks_accept: got ready=%b valid=%b expected 1/0", req_ready[0], res_valid[0]);
      end
      do_op(0, OP_XOR, 64'hF0F0_F0F0, 64'hFF00_FF00, d, l);
      n_checks++;
      if (d !== 64'h0FF0_0FF0 || l !== 1) begin
         n_fail++; $display("FAIL xor_after_flush: got %h/%0d expected 0ff00ff0/1", d, l);
      end
   endtask

   task automatic test_reset_mid_shift();
      bit seen;
      @(negedge clock);
      req_op = OP_SLL;
      req_rs1 = 64'h1;
      req_rs2 = 64'd40;
      req_valid[4] = 1'b1;
      @(negedge clock);
      req_valid[4] = 1'b0;
      repeat (5) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      n_checks++;
      if (req_ready[4] !== 1'b0) begin n_fail++; $display("FAIL reset_mid_ready_low: got %b expected 0", req_ready[4]); end
      reset = 1'b0;
      @(negedge clock);
      n_checks++;
      if (req_ready[4] !== 1'b1 || res_valid[4] !== 1'b0 || rd64[0] !== 64'h0) begin
         n_fail++; $display("FAIL reset_mid_state: got ready=%b valid=%b data=%h expected 1/0/0",
                            req_ready[4], res_valid[4], rd64[0]);
      end
      seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (res_valid[4]) seen = 1'b1;
         @(negedge clock);
      end
      n_checks++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_result: got result=%b expected 0", seen); end
   endtask

   task automatic test_random_sweep();
      logic [63:0] d, a, b, exp_d;
      logic [3:0] op;
      int l, exp_l, sh, xl;
      for (int idx = 0; idx < 7; idx++) begin
         xl = xlen_of(idx);
         for (int n = 0; n < 32; n++) begin
            op = 4'($urandom_range(0, 15));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ((n % 4) == 0) b = 64'($urandom_range(0, 3));
            if ((n % 8) == 1) b = a;
            exp_d = ref_alu(xl, op, a, b);
            sh = int'(b & 64'(xl - 1));
            exp_l = (is_shift(op) && sh != 0) ? 1 + (sh + steps[idx] - 1) / steps[idx] : 1;
            do_op(idx, op, a, b, d, l);
            n_checks++;
            if (d !== exp_d) begin
               n_fail++; $display("FAIL sweep_data inst%0d op%0d a=%h b=%h: got %h expected %h", idx, op, a, b, d, exp_d);
            end
            n_checks++;
            if (l !== exp_l) begin
               n_fail++; $display("FAIL sweep_latency inst%0d op%0d shamt=%0d: got %0d expected %0d", idx, op, sh, l, exp_l);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_shift_step4();
      test_compare();
      test_shamt_zero();
      test_backpressure();
      test_flush();
      test_reset_mid_shift();
      test_random_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
